brute_force_matcher_best_two: RTL

Tracks the two smallest descriptor distances (and their model keypoint IDs) for each query keypoint as the distance engine streams model-vs-query results. At the end of each query's model scan, emits one match table entry. That entry carries both scores in fixed point plus the four keypoint ID fields. It sits directly upstream of the fixed-to-float format conversion stage and drives its valid/data inputs.

---
 rtl/brute_force_matcher_best_two_pkg.sv | 42 ++++
 rtl/brute_force_matcher_best_two_update.sv | 44 ++++
 rtl/brute_force_matcher_best_two.sv | 132 +++++++++++++
 3 files changed

// File: rtl/brute_force_matcher_best_two_pkg.sv
// Shared widths, match-table field layout, FSM encoding and score clamp
// for the best-two brute force matcher.
package brute_force_matcher_best_two_pkg;

    localparam int SCORE_W = 26;
    localparam int QID_W   = 16;
    localparam int MID_W   = 16;

    // Largest representable positive score; also the "no candidate" value.
    localparam logic [SCORE_W-1:0] SMAX = {1'b0, {(SCORE_W-1){1'b1}}};

    // Match table entry, LSB first:
    //   [25:0]    1ST_SCORE
    //   [41:26]   1ST_QUERY_KEYPOINT_ID
    //   [57:42]   1ST_MODEL_KEYPOINT_ID
    //   [83:58]   2ND_SCORE
    //   [99:84]   2ND_QUERY_KEYPOINT_ID
    //   [115:100] 2ND_MODEL_KEYPOINT_ID
    typedef struct packed {
        logic [MID_W-1:0]   mid2;
        logic [QID_W-1:0]   qid2;
        logic [SCORE_W-1:0] score2;
        logic [MID_W-1:0]   mid1;
        logic [QID_W-1:0]   qid1;
        logic [SCORE_W-1:0] score1;
    } match_entry_t;

    localparam int MATCH_TABLE_WIDTH = $bits(match_entry_t);

    // ST_IDLE  | no candidate held
    // ST_ACCUM | at least one candidate held for the current query
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    // Distances with the sign bit set are treated as "very far".
    function automatic logic [SCORE_W-1:0] clamp_score(input logic [SCORE_W-1:0] d);
        return d[SCORE_W-1] ? SMAX : d;
    endfunction

endpackage

// File: rtl/brute_force_matcher_best_two_update.sv
// Combinational best-two insertion: folds one distance into the running
// (best1, best2) pair. Strict compares keep the earlier candidate on ties.
module brute_force_matcher_best_two_update
    import brute_force_matcher_best_two_pkg::*;
(
    input  logic [SCORE_W-1:0] best1_i,
    input  logic [MID_W-1:0]   mid1_i,
    input  logic [SCORE_W-1:0] best2_i,
    input  logic [MID_W-1:0]   mid2_i,
    input  logic [SCORE_W-1:0] d_i,
    input  logic [MID_W-1:0]   mid_i,
    input  logic               first_i,
    output logic [SCORE_W-1:0] best1_o,
    output logic [MID_W-1:0]   mid1_o,
    output logic [SCORE_W-1:0] best2_o,
    output logic [MID_W-1:0]   mid2_o
);

    logic [SCORE_W-1:0] d_c;

    // Insert the clamped distance into the sorted pair.
    always_comb begin
        d_c     = clamp_score(d_i);
        best1_o = best1_i;
        mid1_o  = mid1_i;
        best2_o = best2_i;
        mid2_o  = mid2_i;
        if (first_i) begin
            best1_o = d_c;
            mid1_o  = mid_i;
            best2_o = SMAX;
            mid2_o  = '0;
        end else if (d_c < best1_i) begin
            best2_o = best1_i;
            mid2_o  = mid1_i;
            best1_o = d_c;
            mid1_o  = mid_i;
        end else if (d_c < best2_i) begin
            best2_o = d_c;
            mid2_o  = mid_i;
        end
    end

endmodule

// File: rtl/brute_force_matcher_best_two.sv
// Best-two distance tracker per query keypoint; emits one match table
// entry one cycle after each tlast beat.
// Optional statistics counters: BRUTE_FORCE_MATCHER_BEST_TWO_STATS_EN.
module brute_force_matcher_best_two
    import brute_force_matcher_best_two_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_axis_tvalid,
    input  logic [SCORE_W-1:0]           s_axis_tdata,
    input  logic [QID_W-1:0]             s_axis_tqid,
    input  logic [MID_W-1:0]             s_axis_tmid,
    input  logic                         s_axis_tlast,
    output logic                         m_axis_result_tvalid,
    output logic [MATCH_TABLE_WIDTH-1:0] m_axis_result_tdata,
    output logic                         err_qid
`ifdef BRUTE_FORCE_MATCHER_BEST_TWO_STATS_EN
    ,
    output logic [31:0]                  stat_queries,
    output logic [31:0]                  stat_single
`endif
);

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] best1_q, best2_q, best1_n, best2_n;
    logic [MID_W-1:0]   mid1_q, mid2_q, mid1_n, mid2_n;
    logic [QID_W-1:0]   qid_q;
    logic               out_valid_q;
    match_entry_t       out_data_q;
    match_entry_t       entry_c;
    logic               err_q;
    logic               first_c;
    logic [QID_W-1:0]   entry_qid_c;

    assign first_c     = (state_q == ST_IDLE);
    assign entry_qid_c = first_c ? s_axis_tqid : qid_q;

    brute_force_matcher_best_two_update u_update (
        .best1_i (best1_q),
        .mid1_i  (mid1_q),
        .best2_i (best2_q),
        .mid2_i  (mid2_q),
        .d_i     (s_axis_tdata),
        .mid_i   (s_axis_tmid),
        .first_i (first_c),
        .best1_o (best1_n),
        .mid1_o  (mid1_n),
        .best2_o (best2_n),
        .mid2_o  (mid2_n)
    );

    // Assemble the entry from the post-update values so tlast beats bypass the holding regs.
    always_comb begin
        entry_c        = '0;
        entry_c.score1 = best1_n;
        entry_c.mid1   = mid1_n;
        entry_c.qid1   = entry_qid_c;
        entry_c.score2 = best2_n;
        entry_c.mid2   = mid2_n;
        entry_c.qid2   = entry_qid_c;
    end

    // Next state: any tlast closes the query, otherwise a valid beat keeps accumulating.
    always_comb begin
        state_d = state_q;
        if (s_axis_tvalid) begin
            state_d = s_axis_tlast ? ST_IDLE : ST_ACCUM;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Candidate holding registers, output register and sticky qid error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best1_q     <= SMAX;
            best2_q     <= SMAX;
            mid1_q      <= '0;
            mid2_q      <= '0;
            qid_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (s_axis_tvalid) begin
                if (!first_c && (s_axis_tqid != qid_q)) err_q <= 1'b1;
                if (first_c) qid_q <= s_axis_tqid;
                if (s_axis_tlast) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= entry_c;
                    best1_q     <= SMAX;
                    best2_q     <= SMAX;
                    mid1_q      <= '0;
                    mid2_q      <= '0;
                end else begin
                    best1_q <= best1_n;
                    best2_q <= best2_n;
                    mid1_q  <= mid1_n;
                    mid2_q  <= mid2_n;
                end
            end
        end
    end

    assign m_axis_result_tvalid = out_valid_q;
    assign m_axis_result_tdata  = out_data_q;
    assign err_qid              = err_q;

`ifdef BRUTE_FORCE_MATCHER_BEST_TWO_STATS_EN
    logic [31:0] stat_queries_q, stat_single_q;

    // Entry counters advance on the same edge that raises the output pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_queries_q <= '0;
            stat_single_q  <= '0;
        end else if (s_axis_tvalid && s_axis_tlast) begin
            stat_queries_q <= stat_queries_q + 32'd1;
            if (first_c) stat_single_q <= stat_single_q + 32'd1;
        end
    end

    assign stat_queries = stat_queries_q;
    assign stat_single  = stat_single_q;
`endif

endmodule
